multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-bus MIPS datapath (PC, instruction register, register file, ALU, data memory).
//  Moore FSM: drives every datapath strobe and mux select, one instruction phase per CLK.
//  Adds a MemReady wait handshake for slow memory and a retired-instruction counter.
//  Sits between the instruction register's opcode field and all datapath enables.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter
// PORTS
//  CLK          in   1      clock; all state updates on posedge
//  RESET        in   1      synchronous, active-high reset
//  opcode       in   6      instruction[31:26] from the instruction register (valid from DECODE onward)
//  Zero         in   1      ALU zero flag
//  MemReady     in   1      memory has completed the current read/write this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load if Zero
//  IorD         out  1      0 = memory address from PC, 1 = from ALUOut
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  IRWrite      out  1      instruction register load
//  MemtoReg     out  1      0 = register write data from ALUOut, 1 = from MDR
//  RegDst       out  1      0 = rt, 1 = rd
//  RegWrite     out  1      register file write
//  ALUSrcA      out  1      0 = PC, 1 = register A
//  ALUSrcB      out  2      0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
//  ALUOp        out  2      0 = add, 1 = sub, 2 = use funct field
//  PCSource     out  2      0 = ALU result, 1 = ALUOut, 2 = jump target
//  Illegal      out  1      one-cycle pulse: unsupported opcode seen in DECODE
//  state_dbg    out  4      current state encoding
//  instr_cnt    out  CNT_W  retired instruction count
// BEHAVIOUR
//  States: FETCH(0) DECODE(1) MEMADR(2) MEMRD(3) MEMWB(4) MEMWR(5) EXEC(6) RWB(7) BRANCH(8) ADDIEX(9) ADDIWB(10) JUMP(11).
//  Opcodes: R=0, lw=35, sw=43, beq=4, addi=8, j=2.
//  FETCH:  MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
//          IRWrite=PCWrite=MemReady. MemReady=0 -> stay in FETCH; MemReady=1 -> DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0.
//          Next state by opcode: lw/sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP.
//          Any other opcode -> FETCH with Illegal=1; instr_cnt is not incremented.
//  MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Then lw->MEMRD, sw->MEMWR.
//  MEMRD:  MemRead=1, IorD=1. Hold until MemReady=1, then MEMWB.
//  MEMWR:  MemWrite=1, IorD=1. Hold until MemReady=1, then FETCH.
//  MEMWB:  RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
//  EXEC:   ALUSrcA=1, ALUSrcB=0, ALUOp=2. Then RWB.
//  RWB:    RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Then FETCH.
//  ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Then ADDIWB.
//  ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
//  JUMP:   PCWrite=1, PCSource=2. Then FETCH.
//  Outputs not listed for a state are 0.
//  Retire: instr_cnt += 1 on the edge leaving MEMWB, MEMWR(MemReady), RWB, BRANCH, ADDIWB or JUMP.
//    Counter wraps modulo 2^CNT_W.
//  Latency, zero-wait memory:
//    j/beq 3 cycles; R/addi/sw 4 cycles; lw 5 cycles. Each MemReady=0 cycle adds one.
//  Reset: RESET=1 at posedge -> state=FETCH, instr_cnt=0, regardless of current state (mid-wait included).
//    While RESET=1, all write/strobe outputs (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) and Illegal are forced 0.
//    Select outputs are 0 and state_dbg=0 after the reset edge.
//  RESET takes priority over MemReady and opcode in the same cycle.
//  MemReady is ignored in all states except FETCH, MEMRD and MEMWR.
//  opcode is sampled only in DECODE and MEMADR.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J),
//    state encodings, ALUSrcB/ALUOp/PCSource select constants.
//  Sub-module mips_ctrl_decode: combinational state->control-word decode (plus MemReady gating).
//    The top level holds the state register, next-state logic and counter.
// TESTING
//  Reset: hold RESET 2 cycles -> state_dbg=0, instr_cnt=0; all strobes 0 while RESET=1.
//  R-type: opcode=0, MemReady=1 -> states 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7. instr_cnt=1.
//  lw with waits: opcode=35, MemReady=0 for 2 cycles in FETCH and 1 cycle in MEMRD -> 8 cycles total. IRWrite pulses once.
//  beq: opcode=4 -> PCWriteCond=1, ALUOp=1 in state 8. Toggling Zero never changes the state sequence.
//  Illegal: opcode=63 in DECODE -> Illegal pulses 1 cycle, next state FETCH, instr_cnt unchanged.
//  Reset mid-op: assert RESET during MEMWR while MemReady=0 -> MemWrite=0 that cycle; next state FETCH; instr_cnt=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, state encodings, select constants and control word for the multi-cycle MIPS sequencer
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_J    = 6'd2;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: state -> datapath control word, with FETCH handshake gating and reset blanking
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    input  logic       i_rst,
    output ctrl_t      o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.ir_write  = i_mem_ready;
                w_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = SRCB_IMM_SH;
                w_ctrl.illegal   = !is_legal(i_opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.ior_d    = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.ior_d     = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_op        = ALUOP_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDIWB: w_ctrl.reg_write = 1'b1;
            S_JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    // Everything is blanked during reset so no strobe reaches the datapath mid-reset
    assign o_ctrl = i_rst ? '0 : w_ctrl;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the single-bus multi-cycle MIPS datapath
// with a MemReady wait handshake and a retired-instruction counter.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [5:0]       opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Illegal,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_retire;
    ctrl_t             w_ctrl;
    logic              w_unused_zero;

    // Zero is consumed by the datapath's PCWriteCond gate, not by the sequencer
    assign w_unused_zero = Zero;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: w_next = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                               opcode == OP_R    ? S_EXEC   :
                               opcode == OP_BEQ  ? S_BRANCH :
                               opcode == OP_ADDI ? S_ADDIEX :
                               opcode == OP_J    ? S_JUMP   : S_FETCH;
            S_MEMADR: w_next = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_RWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (MemReady),
        .i_rst       (RESET),
        .o_ctrl      (w_ctrl)
    );

    assign w_retire = r_state == S_MEMWB || (r_state == S_MEMWR && MemReady) || r_state == S_RWB ||
                      r_state == S_BRANCH || r_state == S_ADDIWB || r_state == S_JUMP;

    always_ff @(posedge CLK) begin
        if (RESET)         r_cnt <= '0;
        else if (w_retire) r_cnt <= r_cnt + 1'b1;
    end

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.ior_d;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign Illegal     = w_ctrl.illegal;
    assign state_dbg   = r_state;
    assign instr_cnt   = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vector table plus randomized run against an instruction-path reference model
module tb_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [5:0]  opcode = '0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state_dbg;
    logic [31:0] instr_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Illegal(Illegal), .state_dbg(state_dbg), .instr_cnt(instr_cnt)
    );

    wire [16:0] got_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2};
    endfunction

    // Expected control word straight from the per-state output table
    function automatic logic [16:0] exp_ctrl(input int s, input bit mr, input bit ill, input bit rst);
        logic pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, sa = 0, il = 0;
        logic [1:0] sb = 0, aop = 0, pcs = 0;
        case (s)
            0:  begin mrd = 1; sb = 1; irw = mr; pw = mr; end
            1:  begin sb = 3; il = ill; end
            2:  begin sa = 1; sb = 2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin sa = 1; aop = 2; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin sa = 1; aop = 1; pwc = 1; pcs = 1; end
            9:  begin sa = 1; sb = 2; end
            10: rw = 1;
            11: begin pw = 1; pcs = 2; end
            default: ;
        endcase
        if (rst) return '0;
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs, il};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [5:0] op;
        bit         mr;
        bit         zr;
        int         st;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input int op, input bit mr, input bit zr, input int st, input int cnt);
        vec_t v;
        v.rst = rst; v.op = 6'(op); v.mr = mr; v.zr = zr; v.st = st; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic build_path(input logic [5:0] op, output int p[$]);
        case (op)
            6'd0:    p = {0, 1, 6, 7};
            6'd35:   p = {0, 1, 2, 3, 4};
            6'd43:   p = {0, 1, 2, 5};
            6'd4:    p = {0, 1, 8};
            6'd8:    p = {0, 1, 9, 10};
            6'd2:    p = {0, 1, 11};
            default: p = {0, 1};
        endcase
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 6'd0;
            1: return 6'd35;
            2: return 6'd43;
            3: return 6'd4;
            4: return 6'd8;
            5: return 6'd2;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        int          path[$];
        int          idx;
        int          s;
        logic [31:0] mcnt;
        logic [5:0]  op;
        bit          mr, zr, rst;

        // Reset held for two edges: state and counter cleared, all outputs blanked
        RESET = 1'b1; MemReady = 1'b1; opcode = 6'd35;
        @(posedge CLK);
        @(negedge CLK);
        chk("reset_state", 32'(state_dbg), 0);
        chk("reset_cnt", instr_cnt, 0);
        chk("reset_ctrl", 32'(got_ctrl), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("reset_ctrl2", 32'(got_ctrl), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // R-type
        add(0, 0, 1, 0, 0, 0);  add(0, 0, 1, 0, 1, 0);  add(0, 0, 1, 0, 6, 0);  add(0, 0, 1, 0, 7, 0);
        // lw: two FETCH waits, one MEMRD wait -> 8 cycles
        add(0, 35, 0, 0, 0, 1); add(0, 35, 0, 0, 0, 1); add(0, 35, 1, 0, 0, 1); add(0, 35, 1, 0, 1, 1);
        add(0, 35, 1, 0, 2, 1); add(0, 35, 0, 0, 3, 1); add(0, 35, 1, 0, 3, 1); add(0, 35, 1, 0, 4, 1);
        // beq with Zero toggling
        add(0, 4, 1, 1, 0, 2);  add(0, 4, 1, 0, 1, 2);  add(0, 4, 1, 1, 8, 2);
        // illegal opcode in DECODE
        add(0, 63, 1, 0, 0, 3); add(0, 63, 1, 0, 1, 3);
        // j
        add(0, 2, 1, 0, 0, 3);  add(0, 2, 1, 0, 1, 3);  add(0, 2, 1, 0, 11, 3);
        // addi
        add(0, 8, 1, 0, 0, 4);  add(0, 8, 1, 0, 1, 4);  add(0, 8, 1, 0, 9, 4);  add(0, 8, 1, 0, 10, 4);
        // sw with reset during a MEMWR wait
        add(0, 43, 1, 0, 0, 5); add(0, 43, 1, 0, 1, 5); add(0, 43, 1, 0, 2, 5); add(0, 43, 0, 0, 5, 5);
        add(1, 43, 0, 0, 5, 5); add(0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            RESET = vecs[i].rst; opcode = vecs[i].op; MemReady = vecs[i].mr; Zero = vecs[i].zr;
            @(negedge CLK);
            chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
            chk($sformatf("vec%0d_cnt", i), instr_cnt, 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_ctrl", i), 32'(got_ctrl),
                32'(exp_ctrl(vecs[i].st, vecs[i].mr, !legal(vecs[i].op), vecs[i].rst)));
            @(posedge CLK); #1;
        end

        // Randomized run: model walks each instruction's state path
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        mcnt = 0; idx = 0;
        op = pick_op();
        build_path(op, path);
        for (int c = 0; c < 2000; c++) begin
            mr  = ($urandom_range(0, 3) != 0);
            zr  = 1'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            RESET = rst; MemReady = mr; Zero = zr; opcode = op;
            s = path[idx];
            @(negedge CLK);
            chk("rnd_state", 32'(state_dbg), 32'(s));
            chk("rnd_cnt", instr_cnt, mcnt);
            chk("rnd_ctrl", 32'(got_ctrl), 32'(exp_ctrl(s, mr, !legal(op), rst)));
            @(posedge CLK); #1;
            if (rst) begin
                mcnt = 0; idx = 0;
                op = pick_op();
                build_path(op, path);
            end else if (!((s == 0 || s == 3 || s == 5) && !mr)) begin
                idx++;
                if (idx == path.size()) begin
                    if (legal(op)) mcnt++;
                    idx = 0;
                    op = pick_op();
                    build_path(op, path);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
